sensor_fifo_apb: RTL and testbench

APB slave that buffers multi-channel sensor samples in a FIFO and exposes them through a register map. It generalises the single-sample accelerometer register file: parametrised channel count, sample width and buffer depth, with overflow accounting, a level-threshold interrupt and a spec-compliant APB handshake. It sits between a sensor front-end (for example `accel_spi_master`) and the APB bus.

---
 rtl/sensor_fifo_apb_pkg.sv | 22 ++
 rtl/sensor_sample_fifo.sv | 68 ++++++
 rtl/sensor_fifo_apb.sv | 148 ++++++++++++++
 tb/tb_sensor_fifo_apb.sv | 506 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_fifo_apb_pkg.sv
// sensor_fifo_apb_pkg: register offsets, field positions and widths
// shared by the sensor FIFO APB slave.
package sensor_fifo_apb_pkg;

    localparam logic [31:0] CTRL_OFF    = 32'h00;
    localparam logic [31:0] STATUS_OFF  = 32'h04;
    localparam logic [31:0] THRESH_OFF  = 32'h08;
    localparam logic [31:0] OVF_CNT_OFF = 32'h0C;
    localparam logic [31:0] DATA_BASE   = 32'h10;

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_FLUSH  = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;

    localparam int unsigned ST_EMPTY     = 0;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_OVF       = 2;
    localparam int unsigned ST_LEVEL_LSB = 8;

    localparam int unsigned OVF_CNT_W = 16;

endpackage

// File: rtl/sensor_sample_fifo.sv
// sensor_sample_fifo: circular sample buffer with flush and a
// push-through-pop path that lets a full FIFO accept a new sample.
module sensor_sample_fifo #(
    parameter  int WIDTH = 48,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign level_o = level_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push & ~do_pop) level_d = level_q + LVL_W'(1);
            else if (~do_push & do_pop) level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the pointers and level gate every read.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/sensor_fifo_apb.sv
// sensor_fifo_apb: zero-wait APB register front-end over the sample FIFO,
// with overflow accounting and a registered level/overflow interrupt.
module sensor_fifo_apb
    import sensor_fifo_apb_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                     pclk_i,
    input  logic                     preset_i,
    input  logic [31:0]              paddr_i,
    input  logic                     psel_i,
    input  logic                     penable_i,
    input  logic                     pwrite_i,
    input  logic [31:0]              pwdata_i,
    input  logic [3:0]               pstrb_i,
    output logic                     pready_o,
    output logic [31:0]              prdata_o,
    output logic                     pslverr_o,
    input  logic                     sample_valid_i,
    input  logic [NUM_CH*DATA_W-1:0] sample_data_i,
    output logic                     irq_o
);

    localparam int WIDTH = NUM_CH * DATA_W;
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [31:0] LAST_ADDR = DATA_BASE + 32'(4 * (NUM_CH - 1));

    logic                 en_q, en_d;
    logic                 irq_en_q, irq_en_d;
    logic [7:0]           thresh_q, thresh_d;
    logic                 ovf_q, ovf_d;
    logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic                 irq_q, irq_d;

    logic             access, err, wr_ok, rd_ok;
    logic             push_req, flush, pop, overflow, ovf_clr;
    logic             fifo_full, fifo_empty;
    logic [LVL_W-1:0] fifo_level;
    logic [WIDTH-1:0] fifo_head;
    logic [7:0]       level8;
    logic [31:0]      rdata;
    logic             unused_bits;

    assign access = psel_i & penable_i;
    assign err    = (paddr_i[1:0] != 2'b00) | (paddr_i > LAST_ADDR)
                  | (pwrite_i & (paddr_i >= OVF_CNT_OFF));
    assign wr_ok  = access & pwrite_i & ~err;
    assign rd_ok  = access & ~pwrite_i & ~err;

    assign flush    = wr_ok & (paddr_i == CTRL_OFF) & pstrb_i[0]
                    & pwdata_i[CTRL_FLUSH];
    assign ovf_clr  = wr_ok & (paddr_i == STATUS_OFF) & pstrb_i[0]
                    & pwdata_i[ST_OVF];
    assign pop      = rd_ok & (paddr_i == LAST_ADDR) & ~fifo_empty;
    assign push_req = sample_valid_i & en_q;
    assign overflow = push_req & fifo_full & ~pop & ~flush;
    assign level8   = 8'(fifo_level);

    sensor_sample_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (pclk_i),
        .rst_i   (preset_i),
        .push_i  (push_req & ~flush),
        .pop_i   (pop),
        .flush_i (flush),
        .data_i  (sample_data_i),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level),
        .head_o  (fifo_head)
    );

    always_comb begin
        en_d      = en_q;
        irq_en_d  = irq_en_q;
        thresh_d  = thresh_q;
        ovf_d     = ovf_q;
        ovf_cnt_d = ovf_cnt_q;
        if (wr_ok & pstrb_i[0]) begin
            if (paddr_i == CTRL_OFF) begin
                en_d     = pwdata_i[CTRL_EN];
                irq_en_d = pwdata_i[CTRL_IRQ_EN];
            end
            if (paddr_i == THRESH_OFF) thresh_d = pwdata_i[7:0];
        end
        if (ovf_clr) ovf_d = 1'b0;
        // A same-cycle overflow beats the W1C clear.
        if (overflow) begin
            ovf_d = 1'b1;
            if (ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + OVF_CNT_W'(1);
        end
        if (flush) begin
            ovf_d     = 1'b0;
            ovf_cnt_d = '0;
        end
        irq_d = irq_en_q & (((thresh_q != 8'd0) & (level8 >= thresh_q)) | ovf_q);
    end

    always_comb begin
        rdata = '0;
        if (paddr_i == CTRL_OFF) begin
            rdata[CTRL_EN]     = en_q;
            rdata[CTRL_IRQ_EN] = irq_en_q;
        end else if (paddr_i == STATUS_OFF) begin
            rdata[ST_EMPTY]          = fifo_empty;
            rdata[ST_FULL]           = fifo_full;
            rdata[ST_OVF]            = ovf_q;
            rdata[ST_LEVEL_LSB +: 8] = level8;
        end else if (paddr_i == THRESH_OFF) begin
            rdata[7:0] = thresh_q;
        end else if (paddr_i == OVF_CNT_OFF) begin
            rdata[OVF_CNT_W-1:0] = ovf_cnt_q;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if ((paddr_i == DATA_BASE + 32'(4 * k)) && !fifo_empty)
                rdata[DATA_W-1:0] = fifo_head[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            en_q      <= 1'b0;
            irq_en_q  <= 1'b0;
            thresh_q  <= '0;
            ovf_q     <= 1'b0;
            ovf_cnt_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            en_q      <= en_d;
            irq_en_q  <= irq_en_d;
            thresh_q  <= thresh_d;
            ovf_q     <= ovf_d;
            ovf_cnt_q <= ovf_cnt_d;
            irq_q     <= irq_d;
        end
    end

    assign pready_o    = psel_i & penable_i;
    assign pslverr_o   = access & err;
    assign prdata_o    = (access & ~err) ? rdata : 32'h0;
    assign irq_o       = irq_q;
    assign unused_bits = ^{pwdata_i[31:8], pstrb_i[3:1]};

endmodule

// File: tb/tb_sensor_fifo_apb.sv
// tb_sensor_fifo_apb: directed and randomized checks of sensor_fifo_apb
// against a queue-based model of the register map and sample buffer.
module tb_sensor_fifo_apb;

    localparam int NUM_CH = 3;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int SW     = NUM_CH * DATA_W;
    localparam logic [31:0] LAST = 32'h10 + 32'(4 * (NUM_CH - 1));

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   paddr = '0;
    logic          psel = 1'b0;
    logic          penable = 1'b0;
    logic          pwrite = 1'b0;
    logic [31:0]   pwdata = '0;
    logic [3:0]    pstrb = '0;
    logic          pready;
    logic [31:0]   prdata;
    logic          pslverr;
    logic          sample_valid = 1'b0;
    logic [SW-1:0] sample_data = '0;
    logic          irq;

    int vectors = 0;
    int miscompares = 0;

    logic [SW-1:0] q[$];
    bit            m_en, m_irq_en, m_ovf, m_irq;
    logic [7:0]    m_thresh;
    logic [15:0]   m_cnt;

    sensor_fifo_apb #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .pclk_i         (clk),
        .preset_i       (rst),
        .paddr_i        (paddr),
        .psel_i         (psel),
        .penable_i      (penable),
        .pwrite_i       (pwrite),
        .pwdata_i       (pwdata),
        .pstrb_i        (pstrb),
        .pready_o       (pready),
        .prdata_o       (prdata),
        .pslverr_o      (pslverr),
        .sample_valid_i (sample_valid),
        .sample_data_i  (sample_data),
        .irq_o          (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] exp_read(input logic [31:0] a);
        logic [31:0]   d;
        logic [SW-1:0] s;
        int            k;
        d = '0;
        if (a[1:0] != 2'b00 || a > LAST) return {1'b1, 32'h0};
        if (a == 32'h0) d = {29'd0, m_irq_en, 1'b0, m_en};
        else if (a == 32'h4)
            d = {16'd0, 8'(q.size()), 5'd0, m_ovf,
                 q.size() == DEPTH, q.size() == 0};
        else if (a == 32'h8) d = {24'd0, m_thresh};
        else if (a == 32'hC) d = {16'd0, m_cnt};
        else if (q.size() != 0) begin
            k = int'((a - 32'h10) / 4);
            s = q[0] >> (k * DATA_W);
            d = 32'(s[DATA_W-1:0]);
        end
        return {1'b0, d};
    endfunction

    task automatic model_reset();
        q.delete();
        m_en = 0; m_irq_en = 0; m_ovf = 0; m_irq = 0;
        m_thresh = '0; m_cnt = '0;
    endtask

    task automatic model_edge();
        bit acc, err, wr, fl, pp, ps, oset, irq_n;
        logic [32:0] r;
        acc = psel && penable;
        r = exp_read(paddr);
        err = r[32] || (pwrite && paddr >= 32'hC);
        wr = acc && pwrite && !err;
        irq_n = m_irq_en && ((m_thresh != 0 && q.size() >= m_thresh) || m_ovf);
        fl = wr && paddr == 0 && pstrb[0] && pwdata[1];
        pp = acc && !pwrite && !err && paddr == LAST && q.size() > 0;
        ps = sample_valid && m_en;
        oset = 0;
        if (fl) begin
            q.delete(); m_ovf = 0; m_cnt = '0;
        end else begin
            if (pp) void'(q.pop_front());
            if (ps) begin
                if (q.size() < DEPTH) q.push_back(sample_data);
                else begin
                    oset = 1;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
                end
            end
            if (wr && paddr == 4 && pstrb[0] && pwdata[2]) m_ovf = 0;
            if (oset) m_ovf = 1;
        end
        if (wr && paddr == 0 && pstrb[0]) begin
            m_en = pwdata[0]; m_irq_en = pwdata[2];
        end
        if (wr && paddr == 8 && pstrb[0]) m_thresh = pwdata[7:0];
        m_irq = irq_n;
    endtask

    task automatic step_clk();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic apb_read(input logic [31:0] a, input bit pv,
            input logic [SW-1:0] pd, output logic [31:0] d,
            output logic e, output logic rdy, output logic rdy0,
            output logic [31:0] d0, output logic [32:0] ex);
        psel = 1; penable = 0; pwrite = 0; paddr = a; pstrb = '0;
        #1; rdy0 = pready; d0 = prdata;
        step_clk();
        penable = 1; sample_valid = pv; sample_data = pd;
        #1; d = prdata; e = pslverr; rdy = pready; ex = exp_read(a);
        step_clk();
        psel = 0; penable = 0; sample_valid = 0;
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] wd,
            input logic [3:0] s, input bit pv, input logic [SW-1:0] pd,
            output logic e);
        psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = wd; pstrb = s;
        step_clk();
        penable = 1; sample_valid = pv; sample_data = pd;
        #1; e = pslverr;
        step_clk();
        psel = 0; penable = 0; pwrite = 0; sample_valid = 0;
    endtask

    task automatic push(input logic [SW-1:0] d);
        sample_valid = 1; sample_data = d;
        step_clk();
        sample_valid = 0;
    endtask

    function automatic logic [SW-1:0] rnd_sample();
        return SW'({$urandom, $urandom});
    endfunction

    task automatic test_reset();
        logic [31:0] d, d0;
        logic e, rdy, rdy0;
        logic [32:0] ex;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({irq, pready, pslverr, prdata} !== 35'h0) begin
            miscompares++;
            $display("FAIL reset_idle: got irq=%b rdy=%b err=%b d=%h want 0",
                     irq, pready, pslverr, prdata);
        end
        psel = 1; penable = 1; paddr = 32'h4;
        #1;
        vectors++;
        if (pready !== 1'b1 || prdata !== 32'h1) begin
            miscompares++;
            $display("FAIL reset_access: got rdy=%b d=%h want 1/00000001",
                     pready, prdata);
        end
        psel = 0; penable = 0;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        apb_read(32'h4, 0, '0, d, e, rdy, rdy0, d0, ex);
        vectors++;
        if (rdy0 !== 1'b0 || d0 !== 32'h0) begin
            miscompares++;
            $display("FAIL setup_phase: got rdy=%b d=%h want 0/0", rdy0, d0);
        end
        vectors++;
        if (rdy !== 1'b1 || e !== 1'b0 || d !== 32'h1) begin
            miscompares++;
            $display("FAIL status_reset: got rdy=%b err=%b d=%h want 1/0/1",
                     rdy, e, d);
        end
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_reset: got %b want 0", irq);
        end
    endtask

    task automatic test_reset_midxfer();
        logic [31:0] d, d0;
        logic e, rdy, rdy0;
        logic [32:0] ex;
        apb_write(32'h8, 32'h5, 4'hF, 0, '0, e);
        apb_write(32'h0, 32'h1, 4'hF, 0, '0, e);
        psel = 1; pwrite = 1; paddr = 32'h8; pwdata = 32'h9; pstrb = 4'hF;
        step_clk();
        penable = 1; sample_valid = 1; sample_data = rnd_sample();
        #2; rst = 1;
        @(posedge clk);
        #1;
        rst = 0; psel = 0; penable = 0; pwrite = 0; sample_valid = 0;
        model_reset();
        apb_read(32'h8, 0, '0, d, e, rdy, rdy0, d0, ex);
        vectors++;
        if (d !== 32'h0 || d !== ex[31:0]) begin
            miscompares++;
            $display("FAIL midxfer_thresh: got %h want 00000000", d);
        end
        apb_read(32'h4, 0, '0, d, e, rdy, rdy0, d0, ex);
        vectors++;
        if (d !== 32'h1) begin
            miscompares++;
            $display("FAIL midxfer_status: got %h want 00000001", d);
        end
    endtask

    task automatic test_push_pop();
        logic [31:0] d, d0;
        logic e, rdy, rdy0;
        logic [32:0] ex;
        logic [31:0] want [3];
        want[0] = 32'h1111; want[1] = 32'h2222; want[2] = 32'h3333;
        apb_write(32'h0, 32'h1, 4'hF, 0, '0, e);
        push({16'h3333, 16'h2222, 16'h1111});
        push({16'h6666, 16'h5555, 16'h4444});
        push({16'h9999, 16'h8888, 16'h7777});
        apb_read(32'h4, 0, '0, d, e, rdy, rdy0, d0, ex);
        vectors++;
        if (d !== 32'h0300) begin
            miscompares++;
            $display("FAIL level3: got %h want 00000300", d);
        end
        for (int k = 0; k < 3; k++) begin
            apb_read(32'h10 + 32'(4 * k), 0, '0, d, e, rdy, rdy0, d0, ex);
            vectors++;
            if (d !== want[k] || e !== 1'b0) begin
                miscompares++;
                $display("FAIL data_%0d: got %h err=%b want %h", k, d, e, want[k]);
            end
        end
        apb_read(32'h4, 0, '0, d, e, rdy, rdy0, d0, ex);
        vectors++;
        if (d !== 32'h0200) begin
            miscompares++;
            $display("FAIL level2: got %h want 00000200", d);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d, d0;
        logic e, rdy, rdy0;
        logic [32:0] ex;
        apb_write(32'h0, 32'h3, 4'h1, 0, '0, e);
        for (int i = 0; i < 10; i++) push(rnd_sample());
        apb_read(32'h4, 0, '0, d, e, rdy, rdy0, d0, ex);
        vectors++;
        if (d !== 32'h0806) begin
            miscompares++;
            $display("FAIL ovf_status: got %h want 00000806", d);
        end
        apb_read(32'hC, 0, '0, d, e, rdy, rdy0, d0, ex);
        vectors++;
        if (d !== 32'h2) begin
            miscompares++;
            $display("FAIL ovf_cnt: got %h want 00000002", d);
        end
        apb_write(32'h4, 32'h4, 4'h1, 0, '0, e);
        apb_read(32'h4, 0, '0, d, e, rdy, rdy0, d0, ex);
        vectors++;
        if (d !== 32'h0802) begin
            miscompares++;
            $display("FAIL ovf_w1c: got %h want 00000802", d);
        end
        apb_read(32'hC, 0, '0, d, e, rdy, rdy0, d0, ex);
        vectors++;
        if (d !== 32'h2) begin
            miscompares++;
            $display("FAIL ovf_cnt_keep: got %h want 00000002", d);
        end
        apb_write(32'h4, 32'h4, 4'h1, 1, rnd_sample(), e);
        apb_read(32'h4, 0, '0, d, e, rdy, rdy0, d0, ex);
        vectors++;
        if (d !== 32'h0806) begin
            miscompares++;
            $display("FAIL ovf_set_wins: got %h want 00000806", d);
        end
        apb_read(32'hC, 0, '0, d, e, rdy, rdy0, d0, ex);
        vectors++;
        if (d !== 32'h3) begin
            miscompares++;
            $display("FAIL ovf_cnt_3: got %h want 00000003", d);
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] d, d0;
        logic e, rdy, rdy0;
        logic [32:0] ex;
        logic [SW-1:0] s;
        s = rnd_sample();
        apb_write(32'h4, 32'h4, 4'h1, 0, '0, e);
        apb_read(LAST, 1, s, d, e, rdy, rdy0, d0, ex);
        vectors++;
        if (d !== ex[31:0]) begin
            miscompares++;
            $display("FAIL full_pop_data: got %h want %h", d, ex[31:0]);
        end
        apb_read(32'h4, 0, '0, d, e, rdy, rdy0, d0, ex);
        vectors++;
        if (d !== 32'h0802) begin
            miscompares++;
            $display("FAIL full_pushpop_lvl: got %h want 00000802", d);
        end
        apb_read(32'hC, 0, '0, d, e, rdy, rdy0, d0, ex);
        vectors++;
        if (d !== 32'h3) begin
            miscompares++;
            $display("FAIL full_pushpop_cnt: got %h want 00000003", d);
        end
        for (int i = 0; i < 7; i++) begin
            apb_read(LAST, 0, '0, d, e, rdy, rdy0, d0, ex);
            vectors++;
            if (d !== ex[31:0]) begin
                miscompares++;
                $display("FAIL drain_%0d: got %h want %h", i, d, ex[31:0]);
            end
        end
        apb_read(32'h10, 0, '0, d, e, rdy, rdy0, d0, ex);
        vectors++;
        if (d !== 32'(s[15:0])) begin
            miscompares++;
            $display("FAIL tail_sample: got %h want %h", d, s[15:0]);
        end
    endtask

    task automatic test_irq();
        logic e;
        logic [31:0] d, d0;
        logic rdy, rdy0;
        logic [32:0] ex;
        apb_write(32'h0, 32'h3, 4'h1, 0, '0, e);
        apb_write(32'h8, 32'h4, 4'h1, 0, '0, e);
        apb_write(32'h0, 32'h5, 4'h1, 0, '0, e);
        for (int i = 0; i < 4; i++) push(rnd_sample());
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_lag: got %b want 0", irq);
        end
        step_clk();
        vectors++;
        if (irq !== 1'b1 || irq !== m_irq) begin
            miscompares++;
            $display("FAIL irq_rise: got %b want 1", irq);
        end
        apb_read(LAST, 0, '0, d, e, rdy, rdy0, d0, ex);
        step_clk();
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_fall: got %b want 0", irq);
        end
    endtask

    task automatic test_errors();
        logic [31:0] d, d0;
        logic e, rdy, rdy0;
        logic [32:0] ex;
        logic [31:0] bad [3];
        bad[0] = 32'h40; bad[1] = 32'h06; bad[2] = 32'h1A;
        for (int i = 0; i < 3; i++) begin
            apb_read(bad[i], 0, '0, d, e, rdy, rdy0, d0, ex);
            vectors++;
            if (e !== 1'b1 || d !== 32'h0) begin
                miscompares++;
                $display("FAIL err_read_%h: got err=%b d=%h want 1/0",
                         bad[i], e, d);
            end
        end
        apb_write(32'h10, 32'hFFFF, 4'hF, 0, '0, e);
        vectors++;
        if (e !== 1'b1) begin
            miscompares++;
            $display("FAIL err_wr_data: got %b want 1", e);
        end
        apb_write(32'hC, 32'h0, 4'hF, 0, '0, e);
        vectors++;
        if (e !== 1'b1) begin
            miscompares++;
            $display("FAIL err_wr_cnt: got %b want 1", e);
        end
        apb_write(32'h1, 32'h2, 4'hF, 0, '0, e);
        vectors++;
        if (e !== 1'b1) begin
            miscompares++;
            $display("FAIL err_wr_misalign: got %b want 1", e);
        end
        apb_read(32'h4, 0, '0, d, e, rdy, rdy0, d0, ex);
        vectors++;
        if (d !== ex[31:0] || d[15:8] !== 8'd3) begin
            miscompares++;
            $display("FAIL err_no_effect: got %h want %h", d, ex[31:0]);
        end
    endtask

    task automatic test_flush_push();
        logic [31:0] d, d0;
        logic e, rdy, rdy0;
        logic [32:0] ex;
        for (int i = 0; i < 10; i++) push(rnd_sample());
        apb_write(32'h0, 32'h3, 4'h1, 1, rnd_sample(), e);
        apb_read(32'h4, 0, '0, d, e, rdy, rdy0, d0, ex);
        vectors++;
        if (d !== 32'h1) begin
            miscompares++;
            $display("FAIL flush_status: got %h want 00000001", d);
        end
        apb_read(32'hC, 0, '0, d, e, rdy, rdy0, d0, ex);
        vectors++;
        if (d !== 32'h0) begin
            miscompares++;
            $display("FAIL flush_cnt: got %h want 00000000", d);
        end
        apb_read(LAST, 0, '0, d, e, rdy, rdy0, d0, ex);
        vectors++;
        if (d !== 32'h0 || e !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_read: got %h err=%b want 0/0", d, e);
        end
    endtask

    task automatic test_random();
        logic [31:0] addrs [10];
        addrs[0] = 32'h0;  addrs[1] = 32'h4;  addrs[2] = 32'h8;
        addrs[3] = 32'hC;  addrs[4] = 32'h10; addrs[5] = 32'h14;
        addrs[6] = 32'h18; addrs[7] = 32'h18; addrs[8] = 32'h1C;
        addrs[9] = 32'h2;
        for (int i = 0; i < 500; i++) begin
            int op;
            bit pv;
            logic e, rdy, rdy0;
            logic [31:0] d, d0, wd, a;
            logic [32:0] ex;
            logic [3:0] s;
            op = $urandom_range(0, 9);
            pv = ($urandom_range(0, 2) == 0);
            s = 4'($urandom_range(0, 15));
            if (op <= 3) push(rnd_sample());
            else if (op <= 6) begin
                a = addrs[$urandom_range(0, 9)];
                apb_read(a, pv, rnd_sample(), d, e, rdy, rdy0, d0, ex);
                vectors++;
                if ({e, d} !== ex) begin
                    miscompares++;
                    $display("FAIL rnd_read_%h: got err=%b d=%h want %b/%h",
                             a, e, d, ex[32], ex[31:0]);
                end
            end else if (op == 7) begin
                wd = {29'd0, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 7) == 0),
                      1'($urandom_range(0, 4) != 0)};
                apb_write(32'h0, wd, s, pv, rnd_sample(), e);
            end else if (op == 8) begin
                wd = 32'($urandom_range(0, 9));
                apb_write(32'h8, wd, s, pv, rnd_sample(), e);
            end else begin
                wd = 32'($urandom_range(0, 7));
                apb_write(32'h4, wd, s, pv, rnd_sample(), e);
            end
            vectors++;
            if (irq !== m_irq) begin
                miscompares++;
                $display("FAIL rnd_irq_%0d: got %b want %b", i, irq, m_irq);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_reset_midxfer();
        test_push_pop();
        test_overflow();
        test_full_push_pop();
        test_irq();
        test_errors();
        test_flush_push();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
